// File: rtl/sdp_ram_if.sv
// rtl/sdp_ram_if.sv - write, read and control bundle for sdp_ram
interface sdp_ram_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int NLANES     = 1
);
  logic                  clear;
  logic                  init_done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NLANES-1:0]     wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  init_done, rd_data, rd_valid
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output init_done, rd_data, rd_valid
  );
endinterface

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM with lane enables, RDW policy and clear engine
// Optional SDP_RAM_OUTPUT_REG_EN adds an output register (read latency 2 instead of 1).
module sdp_ram #(
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    RAM_DEPTH   = 4096,
  parameter int                    LANE_WIDTH  = 12,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic       clk,
  input logic       rst_n,
  sdp_ram_if.slave  bus
);

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  localparam int ADDR_WIDTH = clogb2(RAM_DEPTH);
  localparam int NLANES     = DATA_WIDTH / LANE_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  ready;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign ready       = (state == S_READY);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
  assign wr_fire     = ready && bus.wr_en && wr_in_range;
  assign rd_fire     = ready && bus.rd_en;
  assign bus.init_done = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else if (!ready) begin
      if (clr_cnt == LAST_ADDR) state <= S_READY;
      else                      clr_cnt <= clr_cnt + 1'b1;
    end else if (bus.clear) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end
  end

  // Array has no reset; the clear engine owns the write port outside READY.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (wr_fire) begin
      for (int i = 0; i < NLANES; i++) begin
        if (bus.wr_be[i])
          mem[bus.wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= bus.wr_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Unbacked addresses read as CLEAR_VALUE; mode 1 forwards enabled lanes of a colliding write.
  always_comb begin
    rd_word = CLEAR_VALUE;
    if (rd_in_range) begin
      rd_word = mem[bus.rd_addr];
      if (RDW_MODE == 1 && wr_fire && bus.wr_addr == bus.rd_addr) begin
        for (int i = 0; i < NLANES; i++) begin
          if (bus.wr_be[i])
            rd_word[i*LANE_WIDTH +: LANE_WIDTH] = bus.wr_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

`ifdef SDP_RAM_OUTPUT_REG_EN
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_data;
    end
  end

  assign bus.rd_valid = s2_valid;
  assign bus.rd_data  = s2_data;
`else
  assign bus.rd_valid = s1_valid;
  assign bus.rd_data  = s1_data;
`endif

endmodule
